// File: rtl/product_accumulator.sv
// Accumulates a burst of unsigned multiplier products and presents sum, count and overflow.
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN clamps the sum instead of wrapping.
module product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_COUNT = 16,
  localparam int CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               ovf_reg, ovf_next;

  logic [ACC_W:0]     sum_wide;
  logic [CNT_W-1:0]   count_inc;
  logic               carry;
  logic               accept;

  assign in_ready     = (state_reg != HOLD);
  assign out_valid    = (state_reg == HOLD);
  assign out_sum      = acc_reg;
  assign out_count    = count_reg;
  assign out_overflow = ovf_reg;

  assign accept    = in_valid && in_ready;
  assign sum_wide  = {1'b0, acc_reg} + (ACC_W + 1)'(in_prod);
  assign carry     = sum_wide[ACC_W];
  assign count_inc = count_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        // clear wins over a simultaneous accept; that product is dropped
        if (clear) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end else if (accept) begin
          acc_next   = ACC_W'(in_prod);
          count_next = CNT_W'(1);
          ovf_next   = 1'b0;
          state_next = (in_last || (CNT_W'(1) == CNT_W'(MAX_COUNT))) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (clear) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = IDLE;
        end else if (accept) begin
          ovf_next   = ovf_reg | carry;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
          acc_next   = (carry || ovf_reg) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
          acc_next   = sum_wide[ACC_W-1:0];
`endif
          count_next = count_inc;
          if (in_last || (count_inc == CNT_W'(MAX_COUNT)))
            state_next = HOLD;
        end
      end
      HOLD: begin
        // result stays frozen until taken; clear is ignored here
        if (out_ready) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
        count_next = '0;
        ovf_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, clear, out_ready;
  logic [7:0]  in_prod;
  logic        in_ready, out_valid, out_overflow;
  logic [15:0] out_sum;
  logic [4:0]  out_count;

  // second instance with a narrow accumulator for overflow behaviour
  logic        v2, l2, r2, c2;
  logic [7:0]  p2;
  logic        rdy2, ov2, ovf2;
  logic [9:0]  sum2;
  logic [4:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_overflow(out_overflow)
  );

  product_accumulator #(.ACC_W(10)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .in_prod(p2), .in_last(l2), .clear(c2), .out_valid(ov2),
    .out_ready(r2), .out_sum(sum2), .out_count(cnt2),
    .out_overflow(ovf2)
  );

  typedef struct {
    logic [7:0]  prod;
    logic        last;
    logic        exp_valid;
    logic [15:0] exp_sum;
    logic [4:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs change 1ns after a rising edge; outputs are read at the same offset
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] p, input logic l);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; in_prod = p; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_handshake", out_valid, 0);
    check("in_ready_after_handshake", in_ready, 1);
    check("count_cleared", out_count, 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'd225, 1'b1, 1'b1, 16'd225, 5'd1, 1'b0};
    vecs[1] = '{8'd10,  1'b0, 1'b0, 16'd0,   5'd0, 1'b0};
    vecs[2] = '{8'd20,  1'b1, 1'b1, 16'd30,  5'd2, 1'b0};
    vecs[3] = '{8'd255, 1'b0, 1'b0, 16'd0,   5'd0, 1'b0};
    vecs[4] = '{8'd255, 1'b0, 1'b0, 16'd0,   5'd0, 1'b0};
    vecs[5] = '{8'd255, 1'b1, 1'b1, 16'd765, 5'd3, 1'b0};
    vecs[6] = '{8'd0,   1'b1, 1'b1, 16'd0,   5'd1, 1'b0};
    vecs[7] = '{8'd144, 1'b0, 1'b0, 16'd0,   5'd0, 1'b0};
    vecs[8] = '{8'd1,   1'b1, 1'b1, 16'd145, 5'd2, 1'b0};

    rst_n = 1'b0; in_valid = 0; in_last = 0; in_prod = 0; clear = 0; out_ready = 0;
    v2 = 0; l2 = 0; r2 = 0; c2 = 0; p2 = 0;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_count", out_count, 0);
    check("reset_out_overflow", out_overflow, 0);
    rst_n = 1'b1;
    step();

    // table-driven bursts
    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].prod, vecs[i].last);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_out_sum", i), out_sum, vecs[i].exp_sum);
        check($sformatf("vec%0d_out_count", i), out_count, vecs[i].exp_count);
        check($sformatf("vec%0d_out_overflow", i), out_overflow, vecs[i].exp_ovf);
        check($sformatf("vec%0d_in_ready_hold", i), in_ready, 0);
        drain();
      end
      $display("vec %0d prod=%0d last=%0b valid=%0b sum=%0d count=%0d", i,
               vecs[i].prod, vecs[i].last, out_valid, out_sum, out_count);
    end

    // burst held with out_ready low; inputs offered during the hold must be refused
    accept(8'd225, 1'b0);
    accept(8'd36, 1'b0);
    accept(8'd9, 1'b1);
    in_valid = 1'b1; in_prod = 8'd99;
    for (int k = 0; k < 5; k++) begin
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_sum", out_sum, 270);
      check("hold_out_count", out_count, 3);
      step();
    end
    in_valid = 1'b0;
    check("hold_sum_after_stall", out_sum, 270);
    drain();
    $display("hold burst done sum=%0d count=%0d", out_sum, out_count);

    // auto-close at MAX_COUNT, 17th product stalled until the handshake
    for (int k = 0; k < 16; k++) begin
      check("autoclose_valid_low", out_valid, 0);
      accept(8'd1, 1'b0);
    end
    check("autoclose_valid", out_valid, 1);
    check("autoclose_sum", out_sum, 16);
    check("autoclose_count", out_count, 16);
    in_valid = 1'b1; in_prod = 8'd5; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("stall_in_ready", in_ready, 0);
      step();
      check("stall_sum_stable", out_sum, 16);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_autoclose_idle", out_valid, 0);
    check("post_autoclose_ready", in_ready, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("stalled_product_valid", out_valid, 1);
    check("stalled_product_sum", out_sum, 5);
    check("stalled_product_count", out_count, 1);
    drain();
    $display("autoclose done");

    // overflow on the 10-bit instance: 5 x 225 = 1125
    for (int k = 0; k < 5; k++) begin
      check("narrow_in_ready", rdy2, 1);
      v2 = 1'b1; p2 = 8'd225; l2 = (k == 4);
      step();
      v2 = 1'b0; l2 = 1'b0;
    end
    check("narrow_valid", ov2, 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    check("narrow_sum_sat", sum2, 1023);
`else
    check("narrow_sum_wrap", sum2, 101);
`endif
    check("narrow_count", cnt2, 5);
    check("narrow_overflow", ovf2, 1);
    r2 = 1'b1;
    step();
    r2 = 1'b0;
    check("narrow_overflow_cleared", ovf2, 0);
    check("narrow_valid_cleared", ov2, 0);
    $display("narrow overflow burst sum=%0d", sum2);

    // clear with a simultaneous product, then a clean burst, then clear in HOLD
    accept(8'd50, 1'b0);
    in_valid = 1'b1; in_prod = 8'd100; clear = 1'b1;
    check("clear_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0; clear = 1'b0;
    check("clear_valid", out_valid, 0);
    check("clear_count", out_count, 0);
    check("clear_ready", in_ready, 1);
    accept(8'd7, 1'b1);
    check("after_clear_valid", out_valid, 1);
    check("after_clear_sum", out_sum, 7);
    check("after_clear_count", out_count, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_in_hold_valid", out_valid, 1);
    check("clear_in_hold_sum", out_sum, 7);
    drain();
    $display("clear sequence done");

    // asynchronous reset between edges, both mid-burst and in HOLD
    accept(8'd30, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_midburst_count", out_count, 0);
    check("async_midburst_sum", out_sum, 0);
    step();
    rst_n = 1'b1;
    step();
    accept(8'd100, 1'b1);
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_hold_valid", out_valid, 0);
    check("async_hold_sum", out_sum, 0);
    check("async_hold_count", out_count, 0);
    check("async_hold_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    accept(8'd4, 1'b1);
    check("post_reset_valid", out_valid, 1);
    check("post_reset_sum", out_sum, 4);
    check("post_reset_count", out_count, 1);
    drain();
    $display("async reset sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
